// File: rtl/sc_pkg.sv
// sc_pkg: shared definitions for the sc_config_sequencer codebase slice.
//   - sequencer state encoding
//   - config word indices in the staging/active banks
//   - bit-field positions inside the timing words
//   - validation error bit positions
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCheck,
        StApply
    } sc_state_e;

    localparam int unsigned SC_NUM_WORDS = 8;

    // Word indices (cfg_addr values)
    localparam logic [2:0] SC_W_HCFG  = 3'd0;
    localparam logic [2:0] SC_W_HCFG2 = 3'd1;
    localparam logic [2:0] SC_W_VCFG  = 3'd2;
    localparam logic [2:0] SC_W_VCFG2 = 3'd3;
    localparam logic [2:0] SC_W_XY    = 3'd4;
    localparam logic [2:0] SC_W_MISC  = 3'd5;
    localparam logic [2:0] SC_W_SL    = 3'd6;
    localparam logic [2:0] SC_W_SL2   = 3'd7;

    // h_out_config / h_out_config2 fields
    localparam int unsigned H_SYNC_LSB  = 20;
    localparam int unsigned H_SYNC_W    = 9;
    localparam int unsigned H_BP_LSB    = 11;
    localparam int unsigned H_BP_W      = 9;
    localparam int unsigned H_ACT_LSB   = 0;
    localparam int unsigned H_ACT_W     = 11;
    localparam int unsigned H_TOTAL_LSB = 0;
    localparam int unsigned H_TOTAL_W   = 12;

    // v_out_config / v_out_config2 fields
    localparam int unsigned V_SYNC_LSB  = 20;
    localparam int unsigned V_SYNC_W    = 5;
    localparam int unsigned V_BP_LSB    = 11;
    localparam int unsigned V_BP_W      = 9;
    localparam int unsigned V_ACT_LSB   = 0;
    localparam int unsigned V_ACT_W     = 11;
    localparam int unsigned V_TOTAL_LSB = 0;
    localparam int unsigned V_TOTAL_W   = 11;
    localparam int unsigned V_START_LSB = 11;
    localparam int unsigned V_START_W   = 11;

    // cfg_err bit positions
    localparam int unsigned SC_ERR_H      = 0;
    localparam int unsigned SC_ERR_V      = 1;
    localparam int unsigned SC_ERR_VSTART = 2;

endpackage

// File: rtl/sc_config_sequencer_if.sv
// sc_config_sequencer_if: CPU-side config write/commit bus.
//   cfg_wr     write strobe, accepted when cfg_wr & cfg_ready
//   cfg_addr   word index (see sc_pkg SC_W_*)
//   cfg_data   write data
//   cfg_commit commit request, accepted when cfg_commit & cfg_ready
//   cfg_ready  sequencer idle and accepting writes/commits
interface sc_config_sequencer_if;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_commit;
    logic        cfg_ready;

    modport master (
        output cfg_wr,
        output cfg_addr,
        output cfg_data,
        output cfg_commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_wr,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_commit,
        output cfg_ready
    );
endinterface

// File: rtl/sc_cfg_check.sv
// sc_cfg_check: validates staged output timing and registers a 3-bit error vector.
// Ports:
//   PCLK_OUT_i  output pixel clock
//   reset_n     synchronous active-low reset
//   h_cfg_i     h_out_config[28:0]   (sync/bp/active)
//   h_cfg2_i    h_out_config2[11:0]  (H_TOTAL)
//   v_cfg_i     v_out_config[24:0]   (sync/bp/active)
//   v_cfg2_i    v_out_config2[21:0]  (V_STARTLINE/V_TOTAL)
//   err_o       registered failure bits (sc_pkg SC_ERR_*)
module sc_cfg_check
    import sc_pkg::*;
(
    input  logic        PCLK_OUT_i,
    input  logic        reset_n,
    input  logic [28:0] h_cfg_i,
    input  logic [11:0] h_cfg2_i,
    input  logic [24:0] v_cfg_i,
    input  logic [21:0] v_cfg2_i,
    output logic [2:0]  err_o
);

    logic [H_SYNC_W-1:0]  h_sync;
    logic [H_BP_W-1:0]    h_bp;
    logic [H_ACT_W-1:0]   h_act;
    logic [H_TOTAL_W-1:0] h_total;
    logic [V_SYNC_W-1:0]  v_sync;
    logic [V_BP_W-1:0]    v_bp;
    logic [V_ACT_W-1:0]   v_act;
    logic [V_TOTAL_W-1:0] v_total;
    logic [V_START_W-1:0] v_start;
    logic [12:0]          h_sum;
    logic [11:0]          v_sum;
    logic [2:0]           err_d;
    logic [2:0]           err_q;

    assign h_sync  = h_cfg_i[H_SYNC_LSB +: H_SYNC_W];
    assign h_bp    = h_cfg_i[H_BP_LSB +: H_BP_W];
    assign h_act   = h_cfg_i[H_ACT_LSB +: H_ACT_W];
    assign h_total = h_cfg2_i[H_TOTAL_LSB +: H_TOTAL_W];
    assign v_sync  = v_cfg_i[V_SYNC_LSB +: V_SYNC_W];
    assign v_bp    = v_cfg_i[V_BP_LSB +: V_BP_W];
    assign v_act   = v_cfg_i[V_ACT_LSB +: V_ACT_W];
    assign v_total = v_cfg2_i[V_TOTAL_LSB +: V_TOTAL_W];
    assign v_start = v_cfg2_i[V_START_LSB +: V_START_W];

    // Sums are widened so no field combination can wrap.
    assign h_sum = 13'(h_sync) + 13'(h_bp) + 13'(h_act);
    assign v_sum = 12'(v_sync) + 12'(v_bp) + 12'(v_act);

    always_comb begin
        err_d                = '0;
        err_d[SC_ERR_H]      = (h_sum > 13'(h_total)) || (h_total < 12'd2);
        err_d[SC_ERR_V]      = v_sum > 12'(v_total);
        err_d[SC_ERR_VSTART] = (v_start == '0) || (v_start >= v_total);
    end

    always_ff @(posedge PCLK_OUT_i) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/sc_config_sequencer.sv
// sc_config_sequencer: frame-synchronous config controller for the output scan converter.
// CPU writes land in a staging bank; a commit waits for the next falling edge of VSYNC_i
// (or a timeout), optionally validates the staged timing, then copies all eight words to
// the active bank in a single edge.
// Build option: define SC_CFG_CHECK_EN to include the CHECK state and validator.
// Ports:
//   PCLK_OUT_i       output pixel clock (only clock)
//   reset_n          synchronous active-low reset
//   bus              config write/commit bus (slave side)
//   VSYNC_i          scan converter VSYNC (active low)
//   *_config*_o      eight active config words
//   cfg_valid_o      at least one commit applied since reset
//   cfg_done_o       one-cycle pulse on the apply edge
//   cfg_err_o        sticky validation failure bits (0 without SC_CFG_CHECK_EN)
//   cfg_forced_o     sticky: last commit taken on timeout
module sc_config_sequencer
    import sc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4194304,
    parameter int unsigned TIMEOUT_W      = 23
) (
    input  logic                 PCLK_OUT_i,
    input  logic                 reset_n,
    sc_config_sequencer_if.slave bus,
    input  logic                 VSYNC_i,
    output logic [31:0]          h_out_config_o,
    output logic [31:0]          h_out_config2_o,
    output logic [31:0]          v_out_config_o,
    output logic [31:0]          v_out_config2_o,
    output logic [31:0]          xy_out_config_o,
    output logic [31:0]          misc_config_o,
    output logic [31:0]          sl_config_o,
    output logic [31:0]          sl_config2_o,
    output logic                 cfg_valid_o,
    output logic                 cfg_done_o,
    output logic [2:0]           cfg_err_o,
    output logic                 cfg_forced_o
);

    sc_state_e            state_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 vsync_prev_q;
    logic                 valid_q;
    logic                 done_q;
    logic                 forced_q;
    logic [31:0]          stage_q [SC_NUM_WORDS];
    logic [31:0]          act_q   [SC_NUM_WORDS];

    logic ready;
    logic wr_acc;
    logic commit_acc;
    logic vsync_fall;
    logic timeout;

    assign ready      = (state_q == StIdle);
    assign wr_acc     = bus.cfg_wr & ready;
    assign commit_acc = bus.cfg_commit & ready;
    assign vsync_fall = vsync_prev_q & ~VSYNC_i;
    assign timeout    = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef SC_CFG_CHECK_EN
    logic [2:0] chk_err;
    logic [2:0] err_q;
    localparam sc_state_e ArmedNext = StCheck;

    // Staging is frozen while ARMED, so the result registered on the ARMED exit edge
    // reflects exactly the words that will be applied.
    sc_cfg_check u_check (
        .PCLK_OUT_i (PCLK_OUT_i),
        .reset_n    (reset_n),
        .h_cfg_i    (stage_q[SC_W_HCFG][28:0]),
        .h_cfg2_i   (stage_q[SC_W_HCFG2][11:0]),
        .v_cfg_i    (stage_q[SC_W_VCFG][24:0]),
        .v_cfg2_i   (stage_q[SC_W_VCFG2][21:0]),
        .err_o      (chk_err)
    );

    assign cfg_err_o = err_q;
`else
    localparam sc_state_e ArmedNext = StApply;

    assign cfg_err_o = 3'b000;
`endif

    always_ff @(posedge PCLK_OUT_i) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            vsync_prev_q <= 1'b1;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            forced_q     <= 1'b0;
            for (int i = 0; i < SC_NUM_WORDS; i++) begin
                stage_q[i] <= '0;
                act_q[i]   <= '0;
            end
`ifdef SC_CFG_CHECK_EN
            err_q        <= '0;
`endif
        end else begin
            vsync_prev_q <= VSYNC_i;
            done_q       <= 1'b0;
            if (wr_acc) begin
                stage_q[bus.cfg_addr] <= bus.cfg_data;
            end
            case (state_q)
                StIdle: begin
                    if (commit_acc) begin
                        forced_q <= 1'b0;
`ifdef SC_CFG_CHECK_EN
                        err_q    <= '0;
`endif
                        state_q  <= StArmed;
                    end
                end
                StArmed: begin
                    // A VSYNC fall wins over a coincident timeout.
                    if (vsync_fall) begin
                        cnt_q   <= '0;
                        state_q <= ArmedNext;
                    end else if (timeout) begin
                        cnt_q    <= '0;
                        forced_q <= 1'b1;
                        state_q  <= ArmedNext;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StCheck: begin
`ifdef SC_CFG_CHECK_EN
                    if (chk_err != 3'b000) begin
                        err_q   <= err_q | chk_err;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StApply;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StApply: begin
                    for (int i = 0; i < SC_NUM_WORDS; i++) begin
                        act_q[i] <= stage_q[i];
                    end
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_ready   = ready;
    assign h_out_config_o  = act_q[SC_W_HCFG];
    assign h_out_config2_o = act_q[SC_W_HCFG2];
    assign v_out_config_o  = act_q[SC_W_VCFG];
    assign v_out_config2_o = act_q[SC_W_VCFG2];
    assign xy_out_config_o = act_q[SC_W_XY];
    assign misc_config_o   = act_q[SC_W_MISC];
    assign sl_config_o     = act_q[SC_W_SL];
    assign sl_config2_o    = act_q[SC_W_SL2];
    assign cfg_valid_o     = valid_q;
    assign cfg_done_o      = done_q;
    assign cfg_forced_o    = forced_q;

endmodule
